// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, register address width, NOP.
// Imported by the hazard controller top and its load-use detector.
package pipe_hazard_ctrl_pkg;

    localparam int         REG_AW_DEF  = 5;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEMWAIT  = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    // addi x0, x0, 0 -- loaded by pipeline registers on bubble or flush
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN     = ST_RUN,
        S_MEMWAIT = ST_MEMWAIT,
        S_ERR     = ST_ERR
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: the load in EX produces a register the DE instruction reads.
// Zero latency; no backpressure of its own.
module hazard_lu_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_load,
    input  logic              i_ex_we,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_de_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic              i_rs1_used,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_rs2_used,
    output logic              o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_rs1_used && (i_rs1 == i_ex_rd);
    assign w_rs2_hit = i_rs2_used && (i_rs2 == i_ex_rd);

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign o_lu = i_ex_valid && i_ex_load && i_ex_we && (i_ex_rd != '0) &&
                  i_de_valid && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush scheduler for the 5-stage pipeline; controls are combinational from state + inputs.
// Memory busy freezes every stage (timeout -> sticky MemErr); HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 16
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              DEValid,
    input  logic [REG_AW-1:0] DERS1,
    input  logic [REG_AW-1:0] DERS2,
    input  logic              DERS1Used,
    input  logic              DERS2Used,
    input  logic [REG_AW-1:0] DERd,
    input  logic              DERWE,
    input  logic              DELS,
    input  logic              DEBranchFlush,
    input  logic              MemBusy,
    input  logic              ErrClr,
    output logic              IFStall,
    output logic              DEStall,
    output logic              EXBubble,
    output logic              EXStall,
    output logic              IFFlush,
    output logic              MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       LUStallCnt,
    output logic [31:0]       MemStallCnt,
    output logic [31:0]       FlushCnt
`endif
);

    hz_state_t         r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_err;
    logic              r_ex_valid;
    logic              r_ex_load;
    logic              r_ex_we;
    logic [REG_AW-1:0] r_ex_rd;
    logic              w_lu;

    hazard_lu_detect #(.REG_AW(REG_AW)) u_lu (
        .i_ex_valid (r_ex_valid),
        .i_ex_load  (r_ex_load),
        .i_ex_we    (r_ex_we),
        .i_ex_rd    (r_ex_rd),
        .i_de_valid (DEValid),
        .i_rs1      (DERS1),
        .i_rs1_used (DERS1Used),
        .i_rs2      (DERS2),
        .i_rs2_used (DERS2Used),
        .o_lu       (w_lu)
    );

    assign MemErr = r_mem_err;

    always_comb begin
        IFStall  = 1'b0;
        DEStall  = 1'b0;
        EXBubble = 1'b0;
        EXStall  = 1'b0;
        IFFlush  = 1'b0;
        if (r_state == S_RUN) begin
            if (MemBusy) begin
                IFStall = 1'b1;
                DEStall = 1'b1;
                EXStall = 1'b1;
            end else if (w_lu) begin
                // branch resolution is deferred: the operand is not ready yet
                IFStall  = 1'b1;
                DEStall  = 1'b1;
                EXBubble = 1'b1;
            end else if (DEValid && DEBranchFlush) begin
                IFFlush = 1'b1;
            end
        end else begin
            IFStall = 1'b1;
            DEStall = 1'b1;
            EXStall = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_to_cnt   <= '0;
            r_mem_err  <= 1'b0;
            r_ex_valid <= 1'b0;
            r_ex_load  <= 1'b0;
            r_ex_we    <= 1'b0;
            r_ex_rd    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (MemBusy) begin
                        r_to_cnt <= TO_W'(1);
                        r_state  <= S_MEMWAIT;
                    end
                end
                S_MEMWAIT: begin
                    if (!MemBusy) begin
                        r_state  <= S_RUN;
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_W'(MEM_TIMEOUT)) begin
                        r_state   <= S_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_ERR: begin
                    if (ErrClr) begin
                        r_state   <= S_RUN;
                        r_mem_err <= 1'b0;
                        r_to_cnt  <= '0;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            // EX shadow mirrors the DE/EX register; it is discarded when leaving the error state
            if (r_state == S_ERR && ErrClr) begin
                r_ex_valid <= 1'b0;
                r_ex_load  <= 1'b0;
                r_ex_we    <= 1'b0;
                r_ex_rd    <= '0;
            end else if (!EXStall) begin
                if (EXBubble || !DEValid) begin
                    r_ex_valid <= 1'b0;
                end else begin
                    r_ex_valid <= 1'b1;
                    r_ex_load  <= DELS;
                    r_ex_rd    <= DERd;
                    r_ex_we    <= DERWE;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            LUStallCnt  <= '0;
            MemStallCnt <= '0;
            FlushCnt    <= '0;
        end else begin
            if (EXBubble)
                LUStallCnt <= LUStallCnt + 32'd1;
            if (EXStall && (r_state != S_RUN))
                MemStallCnt <= MemStallCnt + 32'd1;
            if (IFFlush)
                FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4; inputs change on the falling edge, outputs checked 1 time unit later.
module tb_pipe_hazard_ctrl;

    logic       CLK;
    logic       rst_n;
    logic       DEValid;
    logic [4:0] DERS1;
    logic [4:0] DERS2;
    logic       DERS1Used;
    logic       DERS2Used;
    logic [4:0] DERd;
    logic       DERWE;
    logic       DELS;
    logic       DEBranchFlush;
    logic       MemBusy;
    logic       ErrClr;
    logic       IFStall;
    logic       DEStall;
    logic       EXBubble;
    logic       EXStall;
    logic       IFFlush;
    logic       MemErr;

    int checks;
    int passed;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4), .TO_W(16)) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .DEValid       (DEValid),
        .DERS1         (DERS1),
        .DERS2         (DERS2),
        .DERS1Used     (DERS1Used),
        .DERS2Used     (DERS2Used),
        .DERd          (DERd),
        .DERWE         (DERWE),
        .DELS          (DELS),
        .DEBranchFlush (DEBranchFlush),
        .MemBusy       (MemBusy),
        .ErrClr        (ErrClr),
        .IFStall       (IFStall),
        .DEStall       (DEStall),
        .EXBubble      (EXBubble),
        .EXStall       (EXStall),
        .IFFlush       (IFFlush),
        .MemErr        (MemErr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic de(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic we, input logic ls, input logic br);
        DEValid       = v;
        DERS1         = rs1;
        DERS1Used     = u1;
        DERS2         = rs2;
        DERS2Used     = u2;
        DERd          = rd;
        DERWE         = we;
        DELS          = ls;
        DEBranchFlush = br;
    endtask

    task automatic nx();
        @(negedge CLK);
    endtask

    // expected vector order: {IFStall, DEStall, EXBubble, EXStall, IFFlush}
    task automatic chk(input string tag, input logic [4:0] exp_ctl, input logic exp_err);
        logic [5:0] obs;
        logic [5:0] exp;
        #1;
        obs = {IFStall, DEStall, EXBubble, EXStall, IFFlush, MemErr};
        exp = {exp_ctl, exp_err};
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed={IFs,DEs,Bub,EXs,Fl,Err}=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n   = 1'b0;
        MemBusy = 1'b0;
        ErrClr  = 1'b0;
        de(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);

        nx(); rst_n = 1'b1;
        chk("reset", 5'b00000, 1'b0);

        // load-use on RS1
        nx(); de(1, 0, 0, 0, 0, 10, 1, 1, 0);  chk("lw_x10", 5'b00000, 0);
        nx(); de(1, 10, 1, 0, 0, 11, 1, 0, 0); chk("lu_rs1", 5'b11100, 0);
        nx();                                  chk("lu_rs1_after", 5'b00000, 0);

        // load to x0 never stalls
        nx(); de(1, 0, 0, 0, 0, 0, 1, 1, 0);   chk("lw_x0", 5'b00000, 0);
        nx(); de(1, 0, 1, 0, 1, 12, 1, 0, 0);  chk("x0_reader", 5'b00000, 0);

        // load-use on RS2, then unused RS1 match
        nx(); de(1, 0, 0, 0, 0, 5, 1, 1, 0);   chk("lw_x5", 5'b00000, 0);
        nx(); de(1, 3, 1, 5, 1, 13, 1, 0, 0);  chk("lu_rs2", 5'b11100, 0);
        nx(); de(1, 0, 0, 0, 0, 7, 1, 1, 0);   chk("lw_x7", 5'b00000, 0);
        nx(); de(1, 7, 0, 8, 1, 14, 1, 0, 0);  chk("rs1_unused", 5'b00000, 0);

        // taken branch, and a branch flag without a valid DE instruction
        nx(); de(1, 1, 1, 2, 1, 0, 0, 0, 1);   chk("branch", 5'b00001, 0);
        nx(); de(1, 1, 1, 2, 1, 15, 1, 0, 0);  chk("branch_after", 5'b00000, 0);
        nx(); de(0, 1, 1, 2, 1, 0, 0, 0, 1);   chk("branch_invalid", 5'b00000, 0);

        // branch depending on a load: bubble first, flush next
        nx(); de(1, 0, 0, 0, 0, 10, 1, 1, 0);  chk("lw_x10_b", 5'b00000, 0);
        nx(); de(1, 10, 1, 0, 0, 0, 0, 0, 1);  chk("br_lu_bubble", 5'b11100, 0);
        nx();                                  chk("br_lu_flush", 5'b00001, 0);

        // back-to-back loads, each stalls once
        nx(); de(1, 0, 0, 0, 0, 1, 1, 1, 0);   chk("b2b_lw1", 5'b00000, 0);
        nx(); de(1, 1, 1, 0, 0, 2, 1, 1, 0);   chk("b2b_lw2_stall", 5'b11100, 0);
        nx();                                  chk("b2b_lw2_go", 5'b00000, 0);
        nx(); de(1, 2, 1, 0, 0, 3, 1, 0, 0);   chk("b2b_use_stall", 5'b11100, 0);
        nx();                                  chk("b2b_use_go", 5'b00000, 0);

        // memory wait of 3 busy cycles
        nx(); de(0, 0, 0, 0, 0, 0, 0, 0, 0); MemBusy = 1'b1; chk("mw_busy1", 5'b11010, 0);
        nx();                                  chk("mw_busy2", 5'b11010, 0);
        nx();                                  chk("mw_busy3", 5'b11010, 0);
        nx(); MemBusy = 1'b0;                  chk("mw_exit", 5'b11010, 0);
        nx();                                  chk("mw_run", 5'b00000, 0);

        // MemBusy coinciding with load-use: freeze without bubble, LU re-evaluated on exit
        nx(); de(1, 0, 0, 0, 0, 4, 1, 1, 0);   chk("lw_x4", 5'b00000, 0);
        nx(); de(1, 4, 1, 0, 0, 9, 1, 0, 0); MemBusy = 1'b1; chk("busy_lu", 5'b11010, 0);
        nx(); MemBusy = 1'b0;                  chk("busy_lu_exit", 5'b11010, 0);
        nx();                                  chk("busy_lu_bubble", 5'b11100, 0);
        nx();                                  chk("busy_lu_go", 5'b00000, 0);

        // timeout with MEM_TIMEOUT=4; shadow holds lw x6 while DE reads x6
        nx(); de(1, 0, 0, 0, 0, 6, 1, 1, 0);   chk("lw_x6", 5'b00000, 0);
        nx(); de(1, 6, 1, 0, 0, 9, 1, 0, 0); MemBusy = 1'b1; chk("to_busy1", 5'b11010, 0);
        nx();                                  chk("to_busy2", 5'b11010, 0);
        nx();                                  chk("to_busy3", 5'b11010, 0);
        nx();                                  chk("to_busy4", 5'b11010, 0);
        nx();                                  chk("to_busy5", 5'b11010, 0);
        nx();                                  chk("to_err", 5'b11010, 1);
        nx(); MemBusy = 1'b0;                  chk("to_err_sticky", 5'b11010, 1);
        nx(); ErrClr = 1'b1;                   chk("to_errclr", 5'b11010, 1);
        nx(); ErrClr = 1'b0;                   chk("to_run_shadow_clr", 5'b00000, 0);

        // reset in MEMWAIT
        nx(); de(0, 0, 0, 0, 0, 0, 0, 0, 0); MemBusy = 1'b1; chk("rst_mw_busy1", 5'b11010, 0);
        nx();                                  chk("rst_mw_busy2", 5'b11010, 0);
        nx(); rst_n = 1'b0; MemBusy = 1'b0;
        nx();                                  chk("rst_mw", 5'b00000, 0);
        rst_n = 1'b1;

        // reset in ERR
        nx(); MemBusy = 1'b1;
        repeat (5) nx();
        chk("rst_err_pre", 5'b11010, 1);
        nx(); rst_n = 1'b0; MemBusy = 1'b0;
        nx();                                  chk("rst_err", 5'b00000, 0);
        rst_n = 1'b1;
        nx();                                  chk("rst_err_run", 5'b00000, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
